// File: rtl/audio_echo.sv
// Stereo feedback echo: mixes each codec frame with an attenuated copy of the
// output from iDelay frames earlier, held in a per-channel circular RAM.
module audio_echo #(
  parameter int unsigned DATAW    = 16,
  parameter int unsigned AW       = 12,
  parameter int unsigned FB_SHIFT = 1
) (
  input  logic                    iCLK_50,
  input  logic                    iRST,
  input  logic                    iAUD_LRCK,
  input  logic signed [DATAW-1:0] iLData,
  input  logic signed [DATAW-1:0] iRData,
  input  logic        [AW-1:0]    iDelay,
  input  logic                    iBypass,
  output logic signed [DATAW-1:0] oLData,
  output logic signed [DATAW-1:0] oRData,
  output logic                    oValid,
  output logic                    oClip,
  output logic                    oBusy
);

  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [2:0] {CLR, IDLE, RD, MIX, WR} stateT;

  stateT                   state;
  logic        [AW-1:0]    clrCnt;
  logic        [AW-1:0]    wrPtr;
  logic        [AW-1:0]    rdAddr;
  logic signed [DATAW-1:0] xL, xR;
  logic signed [DATAW-1:0] yL, yR;
  logic                    clipFlag;

  logic lrckMeta, lrckSync, lrckPrev, frameEvt;

  logic signed [DATAW-1:0] ramL [DEPTH];
  logic signed [DATAW-1:0] ramR [DEPTH];
  logic signed [DATAW-1:0] qL, qR;
  logic                    ramWe;
  logic        [AW-1:0]    ramWa;
  logic signed [DATAW-1:0] ramWdL, ramWdR;

  logic [DATAW:0] mixL, mixR;

  // Saturating x + (d >>> FB_SHIFT); MSB of the result is the clip flag.
  function automatic logic [DATAW:0] mixSat(input logic signed [DATAW-1:0] x,
                                            input logic signed [DATAW-1:0] d);
    logic signed [DATAW-1:0] echo;
    logic        [DATAW:0]   sum;
    logic        [DATAW:0]   res;
    echo = d >>> FB_SHIFT;
    sum  = {x[DATAW-1], x} + {echo[DATAW-1], echo};
    if (sum[DATAW] != sum[DATAW-1]) begin
      res = {1'b1, sum[DATAW], {(DATAW-1){~sum[DATAW]}}};
    end else begin
      res = {1'b0, sum[DATAW-1:0]};
    end
    return res;
  endfunction

  assign mixL = mixSat(xL, qL);
  assign mixR = mixSat(xR, qR);

  // LRCK synchroniser and registered rising-edge detect
  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      lrckMeta <= 1'b0;
      lrckSync <= 1'b0;
      lrckPrev <= 1'b0;
      frameEvt <= 1'b0;
    end else begin
      lrckMeta <= iAUD_LRCK;
      lrckSync <= lrckMeta;
      lrckPrev <= lrckSync;
      frameEvt <= lrckSync & ~lrckPrev;
    end
  end

  // RAM port control: clear sweep owns the write port in CLR; a reset during
  // WR suppresses the frame's write.
  always_comb begin
    ramWe  = 1'b0;
    ramWa  = wrPtr;
    ramWdL = yL;
    ramWdR = yR;
    rdAddr = wrPtr - iDelay;
    if (state == CLR) begin
      ramWe  = 1'b1;
      ramWa  = clrCnt;
      ramWdL = '0;
      ramWdR = '0;
    end else if (state == WR && !iRST) begin
      ramWe = 1'b1;
    end
  end

  // Delay RAMs with one-cycle registered read; the address presented in RD
  // is seen as q in MIX.
  always_ff @(posedge iCLK_50) begin
    if (ramWe) begin
      ramL[ramWa] <= ramWdL;
      ramR[ramWa] <= ramWdR;
    end
    qL <= ramL[rdAddr];
    qR <= ramR[rdAddr];
  end

  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      state    <= CLR;
      clrCnt   <= '0;
      wrPtr    <= '0;
      oLData   <= '0;
      oRData   <= '0;
      oValid   <= 1'b0;
      oClip    <= 1'b0;
      oBusy    <= 1'b1;
      xL       <= '0;
      xR       <= '0;
      yL       <= '0;
      yR       <= '0;
      clipFlag <= 1'b0;
    end else begin
      oValid <= 1'b0;
      oClip  <= 1'b0;
      case (state)
        CLR: begin
          clrCnt <= clrCnt + AW'(1);
          if (clrCnt == AW'(DEPTH - 1)) begin
            oBusy <= 1'b0;
            state <= IDLE;
          end
        end
        IDLE: begin
          if (frameEvt) begin
            xL    <= iLData;
            xR    <= iRData;
            state <= RD;
          end
        end
        RD: state <= MIX;
        MIX: begin
          if (iBypass) begin
            yL       <= xL;
            yR       <= xR;
            clipFlag <= 1'b0;
          end else begin
            yL       <= mixL[DATAW-1:0];
            yR       <= mixR[DATAW-1:0];
            clipFlag <= mixL[DATAW] | mixR[DATAW];
          end
          state <= WR;
        end
        WR: begin
          oLData <= yL;
          oRData <= yR;
          oValid <= 1'b1;
          oClip  <= clipFlag;
          wrPtr  <= wrPtr + AW'(1);
          state  <= IDLE;
        end
        default: state <= CLR;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_echo.sv
// Directed bench for audio_echo: a frame-level echo model predicts every
// output, checked each cycle, plus literal expectations per scenario.
module tb_audio_echo;

  localparam int DEPTH = 4096;
  localparam int FB    = 1;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic               rst, lrck, byp;
  logic signed [15:0] lIn, rIn;
  logic        [11:0] dly;
  logic signed [15:0] oL, oR;
  logic               oV, oC, oB;

  audio_echo dut (
    .iCLK_50  (clk),
    .iRST     (rst),
    .iAUD_LRCK(lrck),
    .iLData   (lIn),
    .iRData   (rIn),
    .iDelay   (dly),
    .iBypass  (byp),
    .oLData   (oL),
    .oRData   (oR),
    .oValid   (oV),
    .oClip    (oC),
    .oBusy    (oB)
  );

  typedef struct {
    int l;
    int r;
    int clip;
  } expT;

  int  checks = 0;
  int  errors = 0;
  int  histL[DEPTH];
  int  histR[DEPTH];
  int  mPtr = 0;
  expT expQ[$];
  int  gotL[$];
  int  gotR[$];
  int  gotC[$];
  int  holdL = 0;
  int  holdR = 0;
  int  validCnt = 0;
  bit  prevV = 1'b0;
  expT cur;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // One frame of the echo: read output from 'back' frames ago, mix, store.
  task automatic modelFrame(input int l, input int r, input int d, input bit b);
    int  back, idx, sl, sr;
    expT e;
    back = (d == 0) ? DEPTH : d;
    idx  = (mPtr - back + DEPTH) % DEPTH;
    sl   = l + (histL[idx] >>> FB);
    sr   = r + (histR[idx] >>> FB);
    if (b) begin
      e.l = l; e.r = r; e.clip = 0;
    end else begin
      e.l = sat(sl); e.r = sat(sr);
      e.clip = (sl != e.l || sr != e.r) ? 1 : 0;
    end
    histL[mPtr] = e.l;
    histR[mPtr] = e.r;
    mPtr = (mPtr + 1) % DEPTH;
    expQ.push_back(e);
  endtask

  // Per-cycle output check against the model queue / held values.
  always @(posedge clk) begin
    #1;
    if (oV) begin
      validCnt++;
      check("oValid_one_cycle", int'(prevV), 0);
      if (expQ.size() == 0) begin
        check("unexpected_oValid", 1, 0);
      end else begin
        cur = expQ.pop_front();
        check("oLData", int'(oL), cur.l);
        check("oRData", int'(oR), cur.r);
        check("oClip", int'(oC), cur.clip);
        holdL = cur.l;
        holdR = cur.r;
      end
      gotL.push_back(int'(oL));
      gotR.push_back(int'(oR));
      gotC.push_back(int'(oC));
    end else begin
      check("hold_oLData", int'(oL), holdL);
      check("hold_oRData", int'(oR), holdR);
      check("idle_oClip", int'(oC), 0);
    end
    prevV = oV;
  end

  task automatic clearGot();
    gotL.delete();
    gotR.delete();
    gotC.delete();
  endtask

  task automatic checkGot(input string name, input int idx, input int el,
                          input int er, input int ec);
    if (idx >= gotL.size()) begin
      check({name, "_missing"}, gotL.size(), idx + 1);
    end else begin
      check({name, "_L"}, gotL[idx], el);
      check({name, "_R"}, gotR[idx], er);
      check({name, "_clip"}, gotC[idx], ec);
    end
  endtask

  // Reset for two cycles, then time the clear sweep; an LRCK pulse during
  // the sweep must be dropped.
  task automatic resetDut();
    int cnt, v0;
    @(negedge clk);
    rst = 1'b1;
    lrck = 1'b0;
    holdL = 0;
    holdR = 0;
    expQ.delete();
    for (int i = 0; i < DEPTH; i++) begin
      histL[i] = 0;
      histR[i] = 0;
    end
    mPtr = 0;
    repeat (2) @(negedge clk);
    check("busy_in_reset", int'(oB), 1);
    rst = 1'b0;
    v0 = validCnt;
    cnt = 0;
    while (cnt < 5000) begin
      @(posedge clk);
      cnt++;
      #1;
      if (cnt == 10) lrck = 1'b1;
      if (cnt == 16) lrck = 1'b0;
      if (!oB) break;
    end
    check("sweep_cycles", cnt, DEPTH);
    check("valid_during_sweep", validCnt - v0, 0);
  endtask

  // Drive one frame (8-cycle LRCK period); lat = negedges from pin rise to oValid.
  task automatic sendFrame(input int l, input int r, input int d, input bit b,
                           output int lat);
    @(negedge clk);
    lIn  = 16'(l);
    rIn  = 16'(r);
    dly  = 12'(d);
    byp  = b;
    lrck = 1'b1;
    modelFrame(l, r, d, b);
    lat = 0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (oV && lat == 0) lat = i;
      if (i == 4) lrck = 1'b0;
    end
  endtask

  initial begin
    #(80000 * 20);
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nz, v0;
    rst = 1'b1; lrck = 1'b0; byp = 1'b0;
    lIn = '0; rIn = '0; dly = '0;

    // reset and clear sweep
    resetDut();
    check("idle_busy_low", int'(oB), 0);

    // bypass, then a wet frame reading the bypassed sample (floor shift)
    clearGot();
    sendFrame(1234, -567, 4, 1'b1, lat);
    check("bypass_latency_7to8", (lat >= 7 && lat <= 8) ? 1 : 0, 1);
    sendFrame(0, 0, 1, 1'b0, lat);
    checkGot("bypass", 0, 1234, -567, 0);
    checkGot("floor_echo", 1, 617, -284, 0);

    // impulse echo, delay 4
    resetDut();
    clearGot();
    for (int f = 0; f <= 16; f++)
      sendFrame((f == 0) ? 16000 : 0, (f == 0) ? -16000 : 0, 4, 1'b0, lat);
    checkGot("imp_f0", 0, 16000, -16000, 0);
    checkGot("imp_f3", 3, 0, 0, 0);
    checkGot("imp_f4", 4, 8000, -8000, 0);
    checkGot("imp_f5", 5, 0, 0, 0);
    checkGot("imp_f8", 8, 4000, -4000, 0);
    checkGot("imp_f12", 12, 2000, -2000, 0);
    checkGot("imp_f16", 16, 1000, -1000, 0);

    // saturation, delay 1
    resetDut();
    clearGot();
    for (int f = 0; f < 4; f++) sendFrame(30000, -20000, 1, 1'b0, lat);
    checkGot("sat_f0", 0, 30000, -20000, 0);
    checkGot("sat_f1", 1, 32767, -30000, 1);
    checkGot("sat_f2", 2, 32767, -32768, 1);
    checkGot("sat_f3", 3, 32767, -32768, 1);

    // full depth (delay 0) and a delay-3 echo chain across the pointer wrap
    resetDut();
    clearGot();
    for (int f = 0; f <= 4100; f++)
      sendFrame((f == 0) ? 1000 : (f == 4094) ? 800 : 0, 0,
                (f >= 4094 && f != 4096) ? 3 : 0, 1'b0, lat);
    nz = 0;
    for (int i = 1; i <= 4093 && i < gotL.size(); i++) if (gotL[i] != 0) nz++;
    check("wrap_quiet_frames", nz, 0);
    checkGot("wrap_f0", 0, 1000, 0, 0);
    checkGot("wrap_f4094", 4094, 800, 0, 0);
    checkGot("wrap_f4095", 4095, 0, 0, 0);
    checkGot("wrap_f4096", 4096, 500, 0, 0);
    checkGot("wrap_f4097", 4097, 400, 0, 0);
    checkGot("wrap_f4099", 4099, 250, 0, 0);
    checkGot("wrap_f4100", 4100, 200, 0, 0);

    // reset while a 16000 impulse is in MIX
    v0 = validCnt;
    @(negedge clk);
    lIn = 16'(16000); rIn = '0; dly = 12'(4); byp = 1'b0; lrck = 1'b1;
    repeat (4) @(negedge clk);
    resetDut();
    check("abort_no_valid", validCnt - v0, 0);
    check("abort_out_L", int'(oL), 0);
    clearGot();
    for (int f = 0; f < 12; f++) sendFrame(0, 0, 4, 1'b0, lat);
    nz = 0;
    foreach (gotL[i]) if (gotL[i] != 0 || gotR[i] != 0) nz++;
    check("post_abort_frames", gotL.size(), 12);
    check("post_abort_no_echo", nz, 0);

    repeat (10) @(negedge clk);
    check("pending_expected", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
